writeback_unit: RTL and testbench

- Final pipeline stage of the RISC-V-lite core. Accepts retiring instructions from the memory stage through a valid/ready handshake.
- Selects the result: ALU result, aligned and extended load data, or PC+4 for link.
- Drives the register-file write port (RF_WE, WR_ADDR, DATAIN) consumed by the decode stage.
- Stalls the memory stage while waiting for a load response from data memory.

---
 rtl/writeback_unit_if.sv | 24 ++
 rtl/writeback_unit.sv | 153 +++++++++++++++
 tb/tb_writeback_unit.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_unit_if.sv
// Memory-stage to writeback handshake bundle: one retiring instruction per accept.
interface writeback_unit_if #(
    parameter int nbits = 32,
    parameter int AW    = 5
);
    logic             MEM_VALID;
    logic             MEM_READY;
    logic [nbits-1:0] MEM_ALU_RES;
    logic [nbits-1:0] MEM_NPC4;
    logic [AW-1:0]    MEM_RD;
    logic [1:0]       MEM_WB_SEL;
    logic [2:0]       MEM_LD_FUNCT3;
    logic             MEM_RF_WE;

    modport master (
        output MEM_VALID, MEM_ALU_RES, MEM_NPC4, MEM_RD, MEM_WB_SEL, MEM_LD_FUNCT3, MEM_RF_WE,
        input  MEM_READY
    );

    modport slave (
        input  MEM_VALID, MEM_ALU_RES, MEM_NPC4, MEM_RD, MEM_WB_SEL, MEM_LD_FUNCT3, MEM_RF_WE,
        output MEM_READY
    );
endinterface

// File: rtl/writeback_unit.sv
// Writeback stage: selects ALU / load / PC+4 result and drives the register-file write port.
// Optional macro WB_BYPASS_EN adds decode-stage write-through hit outputs.
module writeback_unit #(
    parameter int nbits = 32,
    parameter int AW    = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    writeback_unit_if.slave      mem,
    input  logic                 DMEM_RVALID,
    input  logic [nbits-1:0]     DMEM_RDATA,
    output logic                 RF_WE,
    output logic [AW-1:0]        WR_ADDR,
    output logic [nbits-1:0]     DATAIN,
    output logic                 WB_BUSY
`ifdef WB_BYPASS_EN
    ,
    input  logic [AW-1:0]        RS1_ADDR,
    input  logic [AW-1:0]        RS2_ADDR,
    output logic                 FWD1_HIT,
    output logic                 FWD2_HIT
`endif
);

    typedef enum logic {
        IDLE,
        WAIT_LOAD
    } state_t;

    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_NPC4 = 2'b10;

    state_t state_q, state_d;

    logic [AW-1:0]    rd_p0;
    logic [1:0]       wb_sel_p0;
    logic [2:0]       funct3_p0;
    logic             rf_we_p0;
    logic [nbits-1:0] npc4_p0;
    logic [nbits-1:0] alu_p0;

    logic             rf_we_d;
    logic [AW-1:0]    wr_addr_d;
    logic [nbits-1:0] datain_d;
    logic             accept;

    // Byte/halfword lane select plus sign or zero extension; undefined funct3 returns the word.
    function automatic logic [nbits-1:0] load_extract(
        input logic [2:0]       f3,
        input logic [1:0]       off,
        input logic [nbits-1:0] word
    );
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  return {{(nbits-8){b[7]}}, b};
            3'b001:  return {{(nbits-16){h[15]}}, h};
            3'b100:  return {{(nbits-8){1'b0}}, b};
            3'b101:  return {{(nbits-16){1'b0}}, h};
            default: return word;
        endcase
    endfunction

    function automatic logic [nbits-1:0] result_sel(
        input logic [1:0]       sel,
        input logic [nbits-1:0] alu,
        input logic [nbits-1:0] npc4,
        input logic [nbits-1:0] ld
    );
        case (sel)
            SEL_LOAD: return ld;
            SEL_NPC4: return npc4;
            default:  return alu;
        endcase
    endfunction

    assign mem.MEM_READY = (state_q == IDLE);
    assign WB_BUSY       = (state_q == WAIT_LOAD);
    assign accept        = mem.MEM_VALID && mem.MEM_READY;

    always_comb begin
        state_d   = state_q;
        rf_we_d   = 1'b0;
        wr_addr_d = WR_ADDR;
        datain_d  = DATAIN;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (mem.MEM_WB_SEL == SEL_LOAD) begin
                        state_d = WAIT_LOAD;
                    end else begin
                        rf_we_d   = mem.MEM_RF_WE && (mem.MEM_RD != '0);
                        wr_addr_d = mem.MEM_RD;
                        datain_d  = result_sel(mem.MEM_WB_SEL, mem.MEM_ALU_RES, mem.MEM_NPC4, '0);
                    end
                end
            end
            WAIT_LOAD: begin
                // A response in the accept cycle is impossible: we only get here one edge later.
                if (DMEM_RVALID) begin
                    rf_we_d   = rf_we_p0 && (rd_p0 != '0);
                    wr_addr_d = rd_p0;
                    datain_d  = result_sel(wb_sel_p0, alu_p0, npc4_p0,
                                           load_extract(funct3_p0, alu_p0[1:0], DMEM_RDATA));
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // p0: captured instruction fields and registered write port
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            RF_WE     <= 1'b0;
            WR_ADDR   <= '0;
            DATAIN    <= '0;
            rd_p0     <= '0;
            wb_sel_p0 <= '0;
            funct3_p0 <= '0;
            rf_we_p0  <= 1'b0;
            npc4_p0   <= '0;
            alu_p0    <= '0;
        end else begin
            state_q <= state_d;
            RF_WE   <= rf_we_d;
            WR_ADDR <= wr_addr_d;
            DATAIN  <= datain_d;
            if (accept) begin
                rd_p0     <= mem.MEM_RD;
                wb_sel_p0 <= mem.MEM_WB_SEL;
                funct3_p0 <= mem.MEM_LD_FUNCT3;
                rf_we_p0  <= mem.MEM_RF_WE;
                npc4_p0   <= mem.MEM_NPC4;
                alu_p0    <= mem.MEM_ALU_RES;
            end
        end
    end

`ifdef WB_BYPASS_EN
    assign FWD1_HIT = RF_WE && (WR_ADDR == RS1_ADDR);
    assign FWD2_HIT = RF_WE && (WR_ADDR == RS2_ADDR);
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed scenarios plus randomized traffic vs a reference model.
module tb_writeback_unit;
    localparam int nbits = 32;
    localparam int AW    = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             dmem_rvalid;
    logic [31:0]      dmem_rdata;
    logic             rf_we;
    logic [4:0]       wr_addr;
    logic [31:0]      datain;
    logic             wb_busy;
`ifdef WB_BYPASS_EN
    logic [4:0]       rs1_addr, rs2_addr;
    logic             fwd1_hit, fwd2_hit;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    writeback_unit_if #(.nbits(nbits), .AW(AW)) mem ();

    writeback_unit #(.nbits(nbits), .AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem         (mem),
        .DMEM_RVALID (dmem_rvalid),
        .DMEM_RDATA  (dmem_rdata),
        .RF_WE       (rf_we),
        .WR_ADDR     (wr_addr),
        .DATAIN      (datain),
        .WB_BUSY     (wb_busy)
`ifdef WB_BYPASS_EN
        ,
        .RS1_ADDR    (rs1_addr),
        .RS2_ADDR    (rs2_addr),
        .FWD1_HIT    (fwd1_hit),
        .FWD2_HIT    (fwd2_hit)
`endif
    );

    // Reference load result computed with shifts from the RISC-V load definitions.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
        int o;
        logic signed [31:0] t;
        o = int'(addr[1:0]);
        case (f3)
            3'b000: begin t = word << (24 - 8 * o); return t >>> 24; end
            3'b001: begin t = word << (16 - 16 * (o / 2)); return t >>> 16; end
            3'b100: return (word >> (8 * o)) & 32'h0000_00FF;
            3'b101: return (word >> (16 * (o / 2))) & 32'h0000_FFFF;
            default: return word;
        endcase
    endfunction

    task automatic drive_idle();
        mem.MEM_VALID     = 1'b0;
        mem.MEM_ALU_RES   = '0;
        mem.MEM_NPC4      = '0;
        mem.MEM_RD        = '0;
        mem.MEM_WB_SEL    = '0;
        mem.MEM_LD_FUNCT3 = '0;
        mem.MEM_RF_WE     = 1'b0;
        dmem_rvalid       = 1'b0;
        dmem_rdata        = '0;
    endtask

    task automatic send(input logic [4:0] rd, input logic [1:0] sel, input logic [2:0] f3,
                        input logic we, input logic [31:0] alu, input logic [31:0] npc4);
        mem.MEM_VALID     = 1'b1;
        mem.MEM_RD        = rd;
        mem.MEM_WB_SEL    = sel;
        mem.MEM_LD_FUNCT3 = f3;
        mem.MEM_RF_WE     = we;
        mem.MEM_ALU_RES   = alu;
        mem.MEM_NPC4      = npc4;
    endtask

    task automatic apply_reset();
        drive_idle();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        tests++; if (rf_we !== 1'b0) begin fails++; $display("FAIL reset_rf_we got %b want 0", rf_we); end
        tests++; if (wr_addr !== 5'd0) begin fails++; $display("FAIL reset_wr_addr got %0d want 0", wr_addr); end
        tests++; if (datain !== 32'd0) begin fails++; $display("FAIL reset_datain got %h want 0", datain); end
        tests++; if (mem.MEM_READY !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", mem.MEM_READY); end
        tests++; if (wb_busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", wb_busy); end
    endtask

    task automatic test_back_to_back();
`ifdef WB_BYPASS_EN
        rs1_addr = 5'd5;
        rs2_addr = 5'd6;
`endif
        send(5'd5, 2'b00, 3'b000, 1'b1, 32'h1234, 32'h0);
        @(negedge clk);
        tests++; if (rf_we !== 1'b1 || wr_addr !== 5'd5 || datain !== 32'h1234)
            begin fails++; $display("FAIL b2b_first got we=%b rd=%0d d=%h want 1/5/00001234", rf_we, wr_addr, datain); end
        tests++; if (mem.MEM_READY !== 1'b1) begin fails++; $display("FAIL b2b_ready got %b want 1", mem.MEM_READY); end
`ifdef WB_BYPASS_EN
        tests++; if (fwd1_hit !== 1'b1 || fwd2_hit !== 1'b0)
            begin fails++; $display("FAIL fwd_first got %b%b want 10", fwd1_hit, fwd2_hit); end
`endif
        send(5'd6, 2'b10, 3'b000, 1'b1, 32'hABCD, 32'h100);
        @(negedge clk);
        drive_idle();
        tests++; if (rf_we !== 1'b1 || wr_addr !== 5'd6 || datain !== 32'h100)
            begin fails++; $display("FAIL b2b_second got we=%b rd=%0d d=%h want 1/6/00000100", rf_we, wr_addr, datain); end
`ifdef WB_BYPASS_EN
        tests++; if (fwd1_hit !== 1'b0 || fwd2_hit !== 1'b1)
            begin fails++; $display("FAIL fwd_second got %b%b want 01", fwd1_hit, fwd2_hit); end
`endif
        @(negedge clk);
        tests++; if (rf_we !== 1'b0 || wr_addr !== 5'd6 || datain !== 32'h100)
            begin fails++; $display("FAIL b2b_hold got we=%b rd=%0d d=%h want 0/6/00000100", rf_we, wr_addr, datain); end
`ifdef WB_BYPASS_EN
        tests++; if (fwd1_hit !== 1'b0 || fwd2_hit !== 1'b0)
            begin fails++; $display("FAIL fwd_after got %b%b want 00", fwd1_hit, fwd2_hit); end
`endif
    endtask

    task automatic test_loads();
        logic [2:0]  f3s   [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] addrs [4] = '{32'h1003, 32'h1003, 32'h2002, 32'h2002};
        logic [31:0] words [4] = '{32'h80FF_FFFF, 32'h80FF_FFFF, 32'h8001_0000, 32'h8001_0000};
        logic [31:0] wants [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001};
        for (int k = 0; k < 4; k++) begin
            send(5'd9 + 5'(k), 2'b01, f3s[k], 1'b1, addrs[k], 32'h0);
            for (int i = 0; i < 3; i++) begin
                if (i == 0) begin @(negedge clk); drive_idle(); end
                else @(negedge clk);
                tests++; if (mem.MEM_READY !== 1'b0 || wb_busy !== 1'b1 || rf_we !== 1'b0)
                    begin fails++; $display("FAIL load%0d_wait%0d got rdy=%b busy=%b we=%b want 0/1/0", k, i, mem.MEM_READY, wb_busy, rf_we); end
            end
            dmem_rvalid = 1'b1;
            dmem_rdata  = words[k];
            @(negedge clk);
            drive_idle();
            tests++; if (rf_we !== 1'b1 || wr_addr !== 5'd9 + 5'(k) || datain !== wants[k])
                begin fails++; $display("FAIL load%0d_data got we=%b rd=%0d d=%h want 1/%0d/%h", k, rf_we, wr_addr, datain, 9 + k, wants[k]); end
            tests++; if (mem.MEM_READY !== 1'b1) begin fails++; $display("FAIL load%0d_ready got %b want 1", k, mem.MEM_READY); end
        end
    endtask

    task automatic test_x0_and_stray();
        send(5'd0, 2'b00, 3'b000, 1'b1, 32'hDEAD, 32'h0);
        @(negedge clk);
        drive_idle();
        tests++; if (rf_we !== 1'b0 || wr_addr !== 5'd0 || datain !== 32'hDEAD)
            begin fails++; $display("FAIL x0_write got we=%b rd=%0d d=%h want 0/0/0000dead", rf_we, wr_addr, datain); end
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h5555_AAAA;
        @(negedge clk);
        drive_idle();
        tests++; if (rf_we !== 1'b0 || mem.MEM_READY !== 1'b1 || wb_busy !== 1'b0 || datain !== 32'hDEAD)
            begin fails++; $display("FAIL stray_rvalid got we=%b rdy=%b busy=%b d=%h want 0/1/0/0000dead", rf_we, mem.MEM_READY, wb_busy, datain); end
        // Response presented on the accept edge must not complete the load.
        send(5'd3, 2'b01, 3'b010, 1'b1, 32'h40, 32'h0);
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h1111_1111;
        @(negedge clk);
        drive_idle();
        tests++; if (rf_we !== 1'b0 || wb_busy !== 1'b1)
            begin fails++; $display("FAIL same_edge_rvalid got we=%b busy=%b want 0/1", rf_we, wb_busy); end
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h2222_3333;
        @(negedge clk);
        drive_idle();
        tests++; if (rf_we !== 1'b1 || wr_addr !== 5'd3 || datain !== 32'h2222_3333)
            begin fails++; $display("FAIL lw_after_same_edge got we=%b rd=%0d d=%h want 1/3/22223333", rf_we, wr_addr, datain); end
    endtask

    task automatic test_reset_in_wait();
        send(5'd7, 2'b01, 3'b010, 1'b1, 32'h80, 32'h0);
        @(negedge clk);
        drive_idle();
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++; if (mem.MEM_READY !== 1'b1 || wb_busy !== 1'b0 || rf_we !== 1'b0 || wr_addr !== 5'd0 || datain !== 32'd0)
            begin fails++; $display("FAIL async_reset got rdy=%b busy=%b we=%b rd=%0d d=%h want 1/0/0/0/0", mem.MEM_READY, wb_busy, rf_we, wr_addr, datain); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h7777_7777;
        @(negedge clk);
        drive_idle();
        tests++; if (rf_we !== 1'b0 || mem.MEM_READY !== 1'b1 || datain !== 32'd0)
            begin fails++; $display("FAIL abandoned_load got we=%b rdy=%b d=%h want 0/1/0", rf_we, mem.MEM_READY, datain); end
    endtask

    task automatic test_random();
        logic [31:0] exp_data;
        logic [4:0]  exp_addr;
        logic        exp_we;
        logic [4:0]  rd;
        logic [1:0]  sel;
        logic [2:0]  f3;
        logic        we;
        logic [31:0] alu, npc4, word;
        int          kind, lat;
        apply_reset();
        exp_data = '0;
        exp_addr = '0;
        for (int n = 0; n < 300; n++) begin
            kind = int'($urandom_range(0, 2));
            rd   = 5'($urandom);
            we   = 1'($urandom);
            alu  = $urandom;
            npc4 = $urandom;
            f3   = 3'($urandom);
            if (kind == 0) begin
                dmem_rvalid = 1'($urandom);
                dmem_rdata  = $urandom;
                @(negedge clk);
                drive_idle();
                tests++; if (rf_we !== 1'b0 || wr_addr !== exp_addr || datain !== exp_data || mem.MEM_READY !== 1'b1)
                    begin fails++; $display("FAIL rnd%0d_idle got we=%b rd=%0d d=%h rdy=%b want 0/%0d/%h/1", n, rf_we, wr_addr, datain, mem.MEM_READY, exp_addr, exp_data); end
            end else if (kind == 1) begin
                case ($urandom_range(0, 2))
                    0:       sel = 2'b00;
                    1:       sel = 2'b10;
                    default: sel = 2'b11;
                endcase
                send(rd, sel, f3, we, alu, npc4);
                @(negedge clk);
                drive_idle();
                exp_we   = we && (rd != 0);
                exp_addr = rd;
                exp_data = (sel == 2'b10) ? npc4 : alu;
                tests++; if (rf_we !== exp_we || wr_addr !== exp_addr || datain !== exp_data)
                    begin fails++; $display("FAIL rnd%0d_alu got we=%b rd=%0d d=%h want %b/%0d/%h", n, rf_we, wr_addr, datain, exp_we, exp_addr, exp_data); end
            end else begin
                lat  = int'($urandom_range(1, 4));
                word = $urandom;
                send(rd, 2'b01, f3, we, alu, npc4);
                @(negedge clk);
                for (int i = 0; i < lat; i++) begin
                    if (i > 0) @(negedge clk);
                    // Offer unrelated traffic while stalled; it must not be taken.
                    send(5'($urandom), 2'($urandom), 3'($urandom), 1'b1, $urandom, $urandom);
                    mem.MEM_VALID = 1'($urandom);
                    tests++; if (mem.MEM_READY !== 1'b0 || rf_we !== 1'b0 || wr_addr !== exp_addr || datain !== exp_data)
                        begin fails++; $display("FAIL rnd%0d_wait got rdy=%b we=%b rd=%0d d=%h want 0/0/%0d/%h", n, mem.MEM_READY, rf_we, wr_addr, datain, exp_addr, exp_data); end
                end
                dmem_rvalid = 1'b1;
                dmem_rdata  = word;
                @(negedge clk);
                drive_idle();
                exp_we   = we && (rd != 0);
                exp_addr = rd;
                exp_data = ref_load(f3, alu, word);
                tests++; if (rf_we !== exp_we || wr_addr !== exp_addr || datain !== exp_data || mem.MEM_READY !== 1'b1)
                    begin fails++; $display("FAIL rnd%0d_load f3=%0d off=%0d got we=%b rd=%0d d=%h want %b/%0d/%h", n, f3, alu[1:0], rf_we, wr_addr, datain, exp_we, exp_addr, exp_data); end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
`ifdef WB_BYPASS_EN
        rs1_addr = '0;
        rs2_addr = '0;
`endif
        test_reset();
        test_back_to_back();
        test_loads();
        test_x0_and_stray();
        test_reset_in_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
